// File: rtl/systolic_feeder.sv
// Systolic array row feeder: skews each accepted row so element i reaches lane i after i+1 advances.
// Latency: lane i output follows acceptance by exactly i+1 en-cycles; tile_done rides with lane LEN-1.
// Backpressure: wready mirrors en; en=0 freezes every stage. Optional flush port: SYSTOLIC_FEEDER_FLUSH_EN.

`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 6
`endif
`ifndef NUMBER_WIDTH
`define NUMBER_WIDTH 32
`endif

module systolic_feeder #(
   parameter int LEN       = `SYS_ARRAY_LEN,
   parameter int WIDTH     = `NUMBER_WIDTH,
   parameter int TILE_ROWS = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
   input  logic                 flush,
`endif
   input  logic                 wvalid,
   output logic                 wready,
   input  logic [LEN*WIDTH-1:0] wdata,
   output logic [LEN*WIDTH-1:0] out_value,
   output logic [LEN-1:0]       out_valid,
   output logic                 tile_done,
   output logic                 busy
);

   localparam int CW = 16;

   logic          flush_w;
   logic          accept_w;
   logic          last_row_w;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LEN-1:0] last_q;
   logic [LEN-1:0] lane_busy;

`ifdef SYSTOLIC_FEEDER_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   // A flushing cycle refuses the offered row so nothing slips past the clear.
   assign wready     = en & ~flush_w;
   assign accept_w   = wvalid & wready;
   assign last_row_w = (cnt_q == CW'(TILE_ROWS - 1));

   // Next row index within the tile, wrapping after the final row.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (last_row_w) begin
         cnt_d = '0;
      end
   end

   // Row counter advances only on accepted rows; flush restarts the tile.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (flush_w) begin
         cnt_q <= '0;
      end else if (accept_w) begin
         cnt_q <= cnt_d;
      end
   end

   // Last-row tag travels beside lane LEN-1; it holds valid&last so its final stage is tile_done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= '0;
      end else if (flush_w) begin
         last_q <= '0;
      end else if (en) begin
         last_q[0] <= accept_w & last_row_w;
         for (int j = 1; j < LEN; j++) begin
            last_q[j] <= last_q[j-1];
         end
      end
   end

   assign tile_done = last_q[LEN-1];

   for (genvar i = 0; i < LEN; i++) begin : g_lane
      logic [WIDTH-1:0] val_q [0:i];
      logic [i:0]       vld_q;

      // Lane i shift chain of i+1 stages; bubbles keep the old value, only valid matters.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= '0;
            for (int j = 0; j <= i; j++) begin
               val_q[j] <= '0;
            end
         end else begin
            if (flush_w) begin
               vld_q <= '0;
            end else if (en) begin
               vld_q[0] <= accept_w;
               for (int j = 1; j <= i; j++) begin
                  vld_q[j] <= vld_q[j-1];
               end
            end
            if (en) begin
               if (accept_w) begin
                  val_q[0] <= wdata[i*WIDTH +: WIDTH];
               end
               for (int j = 1; j <= i; j++) begin
                  val_q[j] <= val_q[j-1];
               end
            end
         end
      end

      assign out_value[i*WIDTH +: WIDTH] = val_q[i];
      assign out_valid[i]                = vld_q[i];
      assign lane_busy[i]                = |vld_q;
   end

   assign busy = |lane_busy;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: directed table, multi-cycle corner sequences, randomized run vs history model.
// The model keeps every en-cycle's accepted row; lane i shows the row from i+1 en-cycles ago.
// Build with SYSTOLIC_FEEDER_FLUSH_EN defined to also exercise the flush port.

module tb_systolic_feeder;

   localparam int LEN  = 6;
   localparam int W    = 32;
   localparam int TR   = 6;
   localparam int MAXH = 8192;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               en = 1'b0;
   logic               wvalid = 1'b0;
   logic               wready;
   logic [LEN*W-1:0]   wdata = '0;
   logic [LEN*W-1:0]   out_value;
   logic [LEN-1:0]     out_valid;
   logic               tile_done;
   logic               busy;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
   logic               flush = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   systolic_feeder #(.LEN(LEN), .WIDTH(W), .TILE_ROWS(TR)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
      .flush     (flush),
`endif
      .wvalid    (wvalid),
      .wready    (wready),
      .wdata     (wdata),
      .out_value (out_value),
      .out_valid (out_valid),
      .tile_done (tile_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: history of en-cycles ----------------
   logic             h_vld  [MAXH];
   logic             h_last [MAXH];
   logic [LEN*W-1:0] h_dat  [MAXH];
   int               n_en = 0;
   int               base = 0;
   int               rows_acc = 0;

   always @(posedge clk or posedge rst) begin
      logic fl;
      logic acc;
      if (rst) begin
         base     = n_en;
         rows_acc = 0;
      end else begin
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
         fl = flush;
`else
         fl = 1'b0;
`endif
         if (en && n_en < MAXH) begin
            acc            = wvalid && !fl;
            h_vld[n_en]    = acc;
            h_dat[n_en]    = wdata;
            h_last[n_en]   = acc && ((rows_acc % TR) == TR - 1);
            if (acc) rows_acc++;
            n_en++;
         end
         if (fl) begin
            base     = n_en;
            rows_acc = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic model_vld(input int idx);
      return (idx >= base) && (idx >= 0) && h_vld[idx];
   endfunction

   task automatic check_model(input string tag);
      logic [LEN-1:0] ev;
      logic eb, ed;
      int idx;
      eb = 1'b0;
      for (int i = 0; i < LEN; i++) begin
         idx   = n_en - 1 - i;
         ev[i] = model_vld(idx);
         if (ev[i]) begin
            eb = 1'b1;
            chk({tag, "_value"}, 64'(out_value[i*W +: W]), 64'(h_dat[idx][i*W +: W]));
         end
      end
      idx = n_en - LEN;
      ed  = model_vld(idx) && h_last[idx];
      chk({tag, "_valid"}, 64'(out_valid), 64'(ev));
      chk({tag, "_busy"}, 64'(busy), 64'(eb));
      chk({tag, "_tile_done"}, 64'(tile_done), 64'(ed));
   endtask

   // One clock: drive at negedge, check wready, advance, check outputs at the following negedge.
   task automatic cyc(input logic e, input logic v, input logic [LEN*W-1:0] d, input string tag);
      logic exp_rdy;
      en = e; wvalid = v; wdata = d;
      #1;
      exp_rdy = e;
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
      if (flush) exp_rdy = 1'b0;
`endif
      chk({tag, "_wready"}, 64'(wready), 64'(exp_rdy));
      @(posedge clk);
      @(negedge clk);
      check_model(tag);
   endtask

   // Asynchronous reset raised between edges; outputs must clear before any clock edge.
   task automatic async_reset(input string tag);
      #2 rst = 1'b1;
      #1;
      chk({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
      chk({tag, "_rst_done"}, 64'(tile_done), 64'd0);
      for (int i = 0; i < LEN; i++) chk({tag, "_rst_value"}, 64'(out_value[i*W +: W]), 64'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [LEN*W-1:0] rand_row();
      logic [LEN*W-1:0] r;
      for (int i = 0; i < LEN; i++) r[i*W +: W] = $urandom;
      return r;
   endfunction

   typedef struct {
      logic           e;
      logic           v;
      logic [LEN-1:0] exp_vld;
      logic           exp_busy;
      logic           exp_done;
   } vec_t;

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      vec_t             tbl [9];
      logic [LEN*W-1:0] row;
      int               pulses, at, l5cnt, l5first, l5last;

      // Single row {1..6}; then en pattern 1,0,0,1 while the row is in flight.
      tbl[0] = '{1'b1, 1'b1, 6'b000001, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 6'b000010, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b0, 6'b000010, 1'b1, 1'b0};
      tbl[3] = '{1'b0, 1'b1, 6'b000010, 1'b1, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 6'b000100, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 6'b001000, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b0, 6'b010000, 1'b1, 1'b0};
      tbl[7] = '{1'b1, 1'b0, 6'b100000, 1'b1, 1'b0};
      tbl[8] = '{1'b1, 1'b0, 6'b000000, 1'b0, 1'b0};
      for (int i = 0; i < LEN; i++) row[i*W +: W] = W'(i + 1);

      // Reset state
      @(negedge clk);
      chk("reset_valid", 64'(out_valid), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(tile_done), 64'd0);
      chk("reset_value", 64'(out_value[W-1:0]), 64'd0);
      chk("reset_wready", 64'(wready), 64'd0);
      rst = 1'b0;

      for (int k = 0; k < 9; k++) begin
         cyc(tbl[k].e, tbl[k].v, tbl[k].v ? row : '0, "tbl");
         chk("tbl_valid", 64'(out_valid), 64'(tbl[k].exp_vld));
         chk("tbl_busy", 64'(busy), 64'(tbl[k].exp_busy));
         chk("tbl_done", 64'(tile_done), 64'(tbl[k].exp_done));
         for (int i = 0; i < LEN; i++)
            if (tbl[k].exp_vld[i]) chk("tbl_lane_value", 64'(out_value[i*W +: W]), 64'(i + 1));
      end

      // Full tile back-to-back: lane LEN-1 valid cycles 6..11, tile_done once at 11.
      en = 1'b0; wvalid = 1'b0;
      async_reset("s029");
      pulses = 0; at = -1; l5cnt = 0; l5first = -1; l5last = -1;
      for (int k = 0; k < 16; k++) begin
         cyc(1'b1, k < 6, rand_row(), "s029");
         if (tile_done) begin pulses++; at = k + 1; end
         if (out_valid[LEN-1]) begin
            l5cnt++;
            if (l5first < 0) l5first = k + 1;
            l5last = k + 1;
         end
      end
      chk("s029_done_pulses", 64'(pulses), 64'd1);
      chk("s029_done_cycle", 64'(at), 64'd11);
      chk("s029_lane5_count", 64'(l5cnt), 64'd6);
      chk("s029_lane5_first", 64'(l5first), 64'd6);
      chk("s029_lane5_last", 64'(l5last), 64'd11);

      // Reset mid-tile: the counter restarts, so five fresh rows do not finish a tile.
      en = 1'b0; wvalid = 1'b0;
      async_reset("s031a");
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, rand_row(), "s031");
      chk("s031_busy_before", 64'(busy), 64'd1);
      async_reset("s031");
      pulses = 0;
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, rand_row(), "s031");
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b0, '0, "s031");
         if (tile_done) pulses++;
      end
      chk("s031_no_done_after_5", 64'(pulses), 64'd0);
      cyc(1'b1, 1'b1, rand_row(), "s031");
      for (int k = 0; k < 7; k++) begin
         cyc(1'b1, 1'b0, '0, "s031");
         if (tile_done) pulses++;
      end
      chk("s031_done_after_6", 64'(pulses), 64'd1);

      // Alternating wvalid; only accepted rows count toward the tile.
      en = 1'b0; wvalid = 1'b0;
      async_reset("s032");
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, (k % 2) == 0, rand_row(), "s032");
         chk("s032_lane0", 64'(out_valid[0]), 64'((k % 2) == 0));
      end
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b1, rand_row(), "s032");
         if (tile_done) pulses++;
      end
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b0, '0, "s032");
         if (tile_done) pulses++;
      end
      chk("s032_done_pulses", 64'(pulses), 64'd1);

`ifdef SYSTOLIC_FEEDER_FLUSH_EN
      // Flush while the sixth row is offered: everything clears, no tile_done, counter restarts.
      en = 1'b0; wvalid = 1'b0;
      async_reset("s033");
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, rand_row(), "s033");
      flush = 1'b1;
      cyc(1'b1, 1'b1, rand_row(), "s033");
      flush = 1'b0;
      chk("s033_busy", 64'(busy), 64'd0);
      chk("s033_valid", 64'(out_valid), 64'd0);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b0, '0, "s033");
         if (tile_done) pulses++;
      end
      chk("s033_no_done", 64'(pulses), 64'd0);
      for (int k = 0; k < 6; k++) begin
         cyc(1'b1, 1'b1, rand_row(), "s033");
         if (tile_done) pulses++;
      end
      for (int k = 0; k < 8; k++) begin
         cyc(1'b1, 1'b0, '0, "s033");
         if (tile_done) pulses++;
      end
      chk("s033_done_fresh_tile", 64'(pulses), 64'd1);
`endif

      // Randomized run against the history model.
      for (int k = 0; k < 2500; k++) begin
         if ($urandom_range(0, 99) == 0) async_reset("rnd");
`ifdef SYSTOLIC_FEEDER_FLUSH_EN
         flush = ($urandom_range(0, 39) == 0);
`endif
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 6, rand_row(), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
